// File: rtl/gpu_mem_pkg.sv
// Shared data-memory types: arbiter FSM states and default bus widths
// used by the LSUs, the arbiter and the memory controller.
package gpu_mem_pkg;

  localparam int MEM_ADDR_BITS = 8;
  localparam int MEM_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELEASE
  } arb_state_e;

endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// Single data-memory channel: one read port and one write port,
// each a valid/ready handshake. master issues, slave answers.
interface lsu_mem_arbiter_if
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS = MEM_ADDR_BITS,
  parameter int DATA_BITS = MEM_DATA_BITS
);

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data,
    output mem_write_valid,
    output mem_write_address,
    output mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data,
    input  mem_write_valid,
    input  mem_write_address,
    input  mem_write_data,
    output mem_write_ready
  );

endinterface

// File: rtl/lsu_mem_arbiter_rr_priority_picker.sv
// Round-robin search: first requester after last_grant, with
// wrap-around modulo NUM_CONSUMERS.
module rr_priority_picker #(
  parameter int NUM_CONSUMERS = 4,
  parameter int IDX_W = $clog2(NUM_CONSUMERS)
) (
  input  logic [NUM_CONSUMERS-1:0] req,
  input  logic [IDX_W-1:0]         last_grant,
  output logic                     found,
  output logic [IDX_W-1:0]         next_grant
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    next_grant = '0;
    idx = '0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % NUM_CONSUMERS);
      if (!found && req[idx]) begin
        found = 1'b1;
        next_grant = idx;
      end
    end
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter serialising per-thread LSU requests onto one
// data-memory channel; one transaction open at a time.
module lsu_mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS = MEM_ADDR_BITS,
  parameter int DATA_BITS = MEM_DATA_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  lsu_mem_arbiter_if.master                  mem
);

  localparam int IDX_W = $clog2(NUM_CONSUMERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSUMERS - 1);

  arb_state_e state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic mrv_q, mrv_d;
  logic [ADDR_BITS-1:0] mra_q, mra_d;
  logic mwv_q, mwv_d;
  logic [ADDR_BITS-1:0] mwa_q, mwa_d;
  logic [DATA_BITS-1:0] mwd_q, mwd_d;
  logic [NUM_CONSUMERS-1:0] crr_q, crr_d;
  logic [NUM_CONSUMERS-1:0] cwr_q, cwr_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] crd_q, crd_d;

  logic [NUM_CONSUMERS-1:0] req;
  logic found;
  logic [IDX_W-1:0] next_grant;
  logic rd_hold;
  logic wr_hold;

  assign req = consumer_read_valid | consumer_write_valid;

  rr_priority_picker #(
    .NUM_CONSUMERS(NUM_CONSUMERS),
    .IDX_W(IDX_W)
  ) u_picker (
    .req(req),
    .last_grant(last_grant_q),
    .found(found),
    .next_grant(next_grant)
  );

  // Hold only on the handshake just completed, so a write queued
  // behind a read on the same LSU can still be re-arbitrated.
  assign rd_hold = crr_q[grant_q] & consumer_read_valid[grant_q];
  assign wr_hold = cwr_q[grant_q] & consumer_write_valid[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_grant_d = last_grant_q;
    mrv_d = mrv_q;
    mra_d = mra_q;
    mwv_d = mwv_q;
    mwa_d = mwa_q;
    mwd_d = mwd_q;
    crr_d = crr_q;
    cwr_d = cwr_q;
    crd_d = crd_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = next_grant;
          last_grant_d = next_grant;
          if (consumer_read_valid[next_grant]) begin
            mrv_d = 1'b1;
            mra_d = consumer_read_address[next_grant*ADDR_BITS +: ADDR_BITS];
            state_d = READ_WAIT;
          end else begin
            mwv_d = 1'b1;
            mwa_d = consumer_write_address[next_grant*ADDR_BITS +: ADDR_BITS];
            mwd_d = consumer_write_data[next_grant*DATA_BITS +: DATA_BITS];
            state_d = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem.mem_read_ready) begin
          mrv_d = 1'b0;
          crr_d[grant_q] = 1'b1;
          crd_d[grant_q*DATA_BITS +: DATA_BITS] = mem.mem_read_data;
          state_d = RELEASE;
        end
      end
      WRITE_WAIT: begin
        if (mem.mem_write_ready) begin
          mwv_d = 1'b0;
          cwr_d[grant_q] = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!rd_hold && !wr_hold) begin
          crr_d[grant_q] = 1'b0;
          cwr_d[grant_q] = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_grant_q <= LAST_IDX;
      mrv_q <= 1'b0;
      mra_q <= '0;
      mwv_q <= 1'b0;
      mwa_q <= '0;
      mwd_q <= '0;
      crr_q <= '0;
      cwr_q <= '0;
      crd_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_grant_q <= last_grant_d;
      mrv_q <= mrv_d;
      mra_q <= mra_d;
      mwv_q <= mwv_d;
      mwa_q <= mwa_d;
      mwd_q <= mwd_d;
      crr_q <= crr_d;
      cwr_q <= cwr_d;
      crd_q <= crd_d;
    end
  end

  assign mem.mem_read_valid = mrv_q;
  assign mem.mem_read_address = mra_q;
  assign mem.mem_write_valid = mwv_q;
  assign mem.mem_write_address = mwa_q;
  assign mem.mem_write_data = mwd_q;
  assign consumer_read_ready = crr_q;
  assign consumer_write_ready = cwr_q;
  assign consumer_read_data = crd_q;

endmodule

// File: doc/lsu_mem_arbiter.md
# lsu_mem_arbiter

Round-robin arbiter sharing one data-memory channel (one read port, one write port) among `NUM_CONSUMERS` per-thread LSUs in a core. Each LSU presents the same valid/ready request protocol it uses towards memory. The arbiter serialises those requests onto the single memory interface, one transaction at a time, and returns read data and completion to the granted LSU only. It sits between the per-thread LSUs and the core's data-memory port.

## Interface

Parameters:
- `NUM_CONSUMERS`, default 4: number of LSUs sharing the channel; must be at least 2.
- `ADDR_BITS`, default 8: memory address width.
- `DATA_BITS`, default 8: memory data width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `consumer_read_valid`  in  NUM_CONSUMERS  per-LSU read request, held until its ready is seen.
- `consumer_read_address`  in  NUM_CONSUMERS×ADDR_BITS  flattened; slice i belongs to LSU i.
- `consumer_read_ready`  out  NUM_CONSUMERS  read completion.
- `consumer_read_data`  out  NUM_CONSUMERS×DATA_BITS  returned data; slice i.
- `consumer_write_valid`  in  NUM_CONSUMERS  per-LSU write request.
- `consumer_write_address`  in  NUM_CONSUMERS×ADDR_BITS  write address.
- `consumer_write_data`  in  NUM_CONSUMERS×DATA_BITS  write data.
- `consumer_write_ready`  out  NUM_CONSUMERS  write completion.
- `mem_read_valid`  out  1  read request to memory.
- `mem_read_address`  out  ADDR_BITS  read address to memory.
- `mem_read_ready`  in  1  memory read done; `mem_read_data` is valid in the same cycle.
- `mem_read_data`  in  DATA_BITS  read data from memory.
- `mem_write_valid`  out  1  write request to memory.
- `mem_write_address`  out  ADDR_BITS  write address to memory.
- `mem_write_data`  out  DATA_BITS  write data to memory.
- `mem_write_ready`  in  1  memory write done.

## Operation

- FSM states:
  - `IDLE`: no transaction open.
  - `READ_WAIT`: read issued, waiting for memory.
  - `WRITE_WAIT`: write issued, waiting for memory.
  - `RELEASE`: completion returned, waiting for the granted LSU to drop its valid.
- Register `last_grant` holds a consumer index. Reset value is `NUM_CONSUMERS-1`, so consumer 0 has top priority after reset.
- Request vector: `req[i] = consumer_read_valid[i] | consumer_write_valid[i]`.
- `IDLE` with any `req` set:
  - Grant the first i with `req[i]` set, searching cyclically from `last_grant+1` with wrap-around modulo `NUM_CONSUMERS`.
  - Latch the grant index into `grant` and `last_grant`.
  - If that consumer's read valid is set, issue a read: set `mem_read_valid` and `mem_read_address`, go to `READ_WAIT`.
  - Otherwise issue a write: set `mem_write_valid`, `mem_write_address` and `mem_write_data`, go to `WRITE_WAIT`.
  - If one consumer asserts read and write valid together, the read is served. The write stays pending and is arbitrated again later.
- `READ_WAIT` on `mem_read_ready`:
  - Clear `mem_read_valid`.
  - Set `consumer_read_ready[grant]` and load `consumer_read_data[grant]` from `mem_read_data`.
  - Go to `RELEASE`.
- `WRITE_WAIT` on `mem_write_ready`: clear `mem_write_valid`, set `consumer_write_ready[grant]`, go to `RELEASE`.
- `RELEASE`, once both valids of `grant` are low: clear that consumer's ready bits, go to `IDLE`.
- Requests from non-granted consumers are ignored until the FSM is back in `IDLE`. They are never dropped, because LSUs hold valid.
- `consumer_read_data[i]` holds its value until the next read completes to consumer i.
- `mem_*_address` and `mem_write_data` hold their last values while the matching valid is low.
- Memory ready while no matching transaction is open is ignored.
- Reset in any state:
  - State goes to `IDLE`, `last_grant` to `NUM_CONSUMERS-1`.
  - All valid, ready, address and data outputs go to 0.
  - Any in-flight memory transaction is abandoned.

## Timing

- Grant latency: a request seen in `IDLE` at edge E drives `mem_*_valid` high after edge E. At most one transaction is open at a time.
- Memory ready sampled at edge M:
  - `mem_*_valid` is low after M.
  - The consumer's ready is high after M.
  - Read data is valid at the consumer after M.
- An LSU that samples ready at M+1 drops valid at M+1. The arbiter sees valid low at M+2, so consumer ready is high exactly 2 cycles, and the FSM is in `IDLE` after M+2.
- Throughput: one transaction per (memory latency + 3) cycles. There is no back-to-back grant without passing through `IDLE`.
- Fairness: while a consumer has a request pending, at most `NUM_CONSUMERS-1` other grants occur before it is served.

## Structure

- Shared package `gpu_mem_pkg`:
  - Arbiter state enum (`IDLE`, `READ_WAIT`, `WRITE_WAIT`, `RELEASE`).
  - Default `ADDR_BITS` / `DATA_BITS` constants, reused by the LSU and the memory controller.
- One combinational sub-module, `rr_priority_picker`:
  - Inputs: `req` vector and `last_grant`.
  - Outputs: `found` and `next_grant` index.
- The FSM, latches and output demux stay in `lsu_mem_arbiter`.

## Test plan

- Single read: consumer 2 reads address 0x3C; memory answers 0x5A after 3 cycles.
  - `mem_read_address`=0x3C.
  - `consumer_read_data[2]`=0x5A with ready high 2 cycles.
  - No other ready toggles.
- Round-robin: all 4 consumers request simultaneously after reset.
  - Grants occur in order 0,1,2,3.
  - A consumer 0 request re-asserted during grant 1 is served after 3.
- Mixed and concurrent:
  - Consumer 1 writes (0x10←0xAB) while consumer 3 reads 0x10, with consumer 1 granted first. Write completes, then the read returns 0xAB.
  - Consumer 0 asserting read and write together has its read served first.
- Zero-latency memory: ready tied high. Each transaction takes exactly 3 cycles (issue, ready, release), with no duplicate `mem_*_valid` cycle per grant.
- Reset mid-`READ_WAIT`: assert reset with a read outstanding.
  - All outputs are 0 next cycle, state `IDLE`.
  - The next grant goes to consumer 0.
  - A late `mem_read_ready` is ignored.
